// File: rtl/dino_jump_ctrl.sv
// dino_jump_ctrl: jump-button conditioning and vertical motion FSM for the dino.
// Ports:
//   clk        master clock, rising edge
//   clr        asynchronous active-low reset
//   tick       one-clk frame strobe; motion advances only on tick cycles
//   jump       raw bouncing jump button (async)
//   game_run   1 = game running; 0 forces GROUND/pos 0
//   is_alive   0 = collision; moves to DEAD and freezes position
//   dino_pos   height above ground (0 = ground), registered
//   dino_state 0 GROUND, 1 ASCEND, 2 HANG, 3 DESCEND, 4 DEAD, registered
//   airborne   registered decode of ASCEND/HANG/DESCEND
//   land       registered one-clk pulse on touchdown
module dino_jump_ctrl #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned MAX_H      = 12,
    parameter int unsigned HANG_TICKS = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       jump,
    input  logic       game_run,
    input  logic       is_alive,
    output logic [3:0] dino_pos,
    output logic [2:0] dino_state,
    output logic       airborne,
    output logic       land
);

    localparam int unsigned DEB_W     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [3:0]  MAX_LVL   = 4'(MAX_H);
    localparam logic [3:0]  HANG_LAST = 4'(HANG_TICKS - 1);

    typedef enum logic [2:0] {
        S_GROUND  = 3'd0,
        S_ASCEND  = 3'd1,
        S_HANG    = 3'd2,
        S_DESCEND = 3'd3,
        S_DEAD    = 3'd4
    } state_e;

    logic [1:0]       sync_q;
    logic             jump_db;
    logic             jump_db_q;
    logic [DEB_W-1:0] deb_cnt;
    logic             db_rise;

    state_e     state_q, state_n;
    logic [3:0] pos_n;
    logic [3:0] hang_cnt, hang_n;
    logic       pending, pend_n;
    logic       land_n;
    logic       airborne_n;

    // Synchronizer plus debouncer: accept a new level only after it has
    // differed from jump_db for DEB_CYCLES consecutive clocks.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_q    <= '0;
            jump_db   <= 1'b0;
            jump_db_q <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            sync_q    <= {sync_q[0], jump};
            jump_db_q <= jump_db;
            if (sync_q[1] != jump_db) begin
                if (deb_cnt == DEB_LAST) begin
                    jump_db <= sync_q[1];
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign db_rise = jump_db & ~jump_db_q;

    // State and output registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= S_GROUND;
            dino_pos <= '0;
            hang_cnt <= '0;
            pending  <= 1'b0;
            land     <= 1'b0;
            airborne <= 1'b0;
        end else begin
            state_q  <= state_n;
            dino_pos <= pos_n;
            hang_cnt <= hang_n;
            pending  <= pend_n;
            land     <= land_n;
            airborne <= airborne_n;
        end
    end

    // Next-state: game_run=0 beats is_alive=0, which beats normal motion.
    // pend_n defaults to 0 so the pending flag only survives in GROUND.
    always_comb begin
        state_n = state_q;
        pos_n   = dino_pos;
        hang_n  = hang_cnt;
        pend_n  = 1'b0;
        land_n  = 1'b0;
        if (!game_run) begin
            state_n = S_GROUND;
            pos_n   = '0;
            hang_n  = '0;
        end else if (!is_alive) begin
            state_n = S_DEAD;
        end else begin
            case (state_q)
                S_GROUND: begin
                    pend_n = pending | db_rise;
                    if (pending && tick) begin
                        pend_n  = 1'b0;
                        pos_n   = 4'd1;
                        hang_n  = '0;
                        state_n = (MAX_LVL == 4'd1) ? S_HANG : S_ASCEND;
                    end
                end
                S_ASCEND: begin
                    if (tick) begin
                        pos_n = dino_pos + 4'd1;
                        if (pos_n == MAX_LVL) begin
                            state_n = S_HANG;
                            hang_n  = '0;
                        end
                    end
                end
                S_HANG: begin
                    if (tick) begin
                        if (hang_cnt == HANG_LAST) begin
                            state_n = S_DESCEND;
                            hang_n  = '0;
                        end else begin
                            hang_n = hang_cnt + 4'd1;
                        end
                    end
                end
                S_DESCEND: begin
                    if (tick) begin
                        pos_n = dino_pos - 4'd1;
                        if (dino_pos == 4'd1) begin
                            state_n = S_GROUND;
                            land_n  = 1'b1;
                        end
                    end
                end
                S_DEAD: begin
                    state_n = S_DEAD;
                end
                default: begin
                    state_n = S_GROUND;
                    pos_n   = '0;
                    hang_n  = '0;
                end
            endcase
        end
        airborne_n = (state_n == S_ASCEND) || (state_n == S_HANG) ||
                     (state_n == S_DESCEND);
    end

    assign dino_state = state_q;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Directed testbench for dino_jump_ctrl with default parameters
// (DEB_CYCLES=16, MAX_H=12, HANG_TICKS=4) and a tick every 4 clocks.
module tb_dino_jump_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       tick;
    logic       jump;
    logic       game_run;
    logic       is_alive;
    logic [3:0] dino_pos;
    logic [2:0] dino_state;
    logic       airborne;
    logic       land;

    int vec_cnt    = 0;
    int miss_cnt   = 0;
    int cyc        = 0;
    int press_left = 0;
    int land_cnt   = 0;
    bit bounce     = 1'b0;

    always #5 clk = ~clk;

    dino_jump_ctrl dut (
        .clk       (clk),
        .clr       (clr),
        .tick      (tick),
        .jump      (jump),
        .game_run  (game_run),
        .is_alive  (is_alive),
        .dino_pos  (dino_pos),
        .dino_state(dino_state),
        .airborne  (airborne),
        .land      (land)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at negedge, sample 1ns after the rising edge.
    task automatic step();
        @(negedge clk);
        tick = (cyc % 4 == 0);
        jump = (press_left > 0) || (bounce && ((cyc / 5) % 2 == 1));
        if (press_left > 0) press_left--;
        cyc++;
        @(posedge clk);
        #1;
        if (land === 1'b1) land_cnt++;
    endtask

    // Step until the next step() will carry a cycle with cyc%4 == c.
    task automatic align(input int c);
        while (cyc % 4 != c) step();
    endtask

    task automatic run_ticks(input int n);
        int t = 0;
        while (t < n) begin
            if (cyc % 4 == 0) t++;
            step();
        end
    endtask

    // Press aligned so clock 20 of the press is a tick edge:
    // 2 sync + 16 debounce + 1 edge detect puts pending up before clock 20.
    task automatic launch(input string tag);
        int n = 0;
        align(1);
        press_left = 20;
        for (int i = 1; i <= 80; i++) begin
            step();
            if (dino_state == 3'd1) begin
                n = i;
                break;
            end
        end
        check({tag, "_launch_clk"}, 8'(n), 8'd20);
        check({tag, "_launch_pos"}, 8'(dino_pos), 8'd1);
    endtask

    // Rest of a full flight, given how many ticks since launch already ran.
    task automatic fly_rest(input string tag, input int done);
        run_ticks(11 - done);
        check({tag, "_apex_pos"}, 8'(dino_pos), 8'd12);
        check({tag, "_apex_state"}, 8'(dino_state), 8'd2);
        check({tag, "_apex_air"}, 8'(airborne), 8'd1);
        run_ticks(3);
        check({tag, "_hang3_state"}, 8'(dino_state), 8'd2);
        run_ticks(1);
        check({tag, "_desc_state"}, 8'(dino_state), 8'd3);
        check({tag, "_desc_pos"}, 8'(dino_pos), 8'd12);
        run_ticks(11);
        check({tag, "_pos1"}, 8'(dino_pos), 8'd1);
        run_ticks(1);
        check({tag, "_land_pos"}, 8'(dino_pos), 8'd0);
        check({tag, "_land_state"}, 8'(dino_state), 8'd0);
        check({tag, "_land_pulse"}, 8'(land), 8'd1);
        check({tag, "_land_air"}, 8'(airborne), 8'd0);
        step();
        check({tag, "_land_drop"}, 8'(land), 8'd0);
        check({tag, "_land_count"}, 8'(land_cnt), 8'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        clr      = 1'b0;
        tick     = 1'b0;
        jump     = 1'b0;
        game_run = 1'b1;
        is_alive = 1'b1;
        #12;
        check("rst_pos", 8'(dino_pos), 8'd0);
        check("rst_state", 8'(dino_state), 8'd0);
        check("rst_air", 8'(airborne), 8'd0);
        check("rst_land", 8'(land), 8'd0);
        @(negedge clk);
        clr = 1'b1;
        repeat (5) step();

        // Clean press, full trajectory
        land_cnt = 0;
        launch("t1");
        fly_rest("t1", 0);
        repeat (30) step();
        check("t1_no_queue", 8'(dino_state), 8'd0);

        // Bounce every 5 clocks never debounces
        bad = 0;
        bounce = 1'b1;
        repeat (100) begin
            step();
            if (dino_pos != 4'd0 || dino_state != 3'd0) bad++;
        end
        bounce = 1'b0;
        repeat (40) step();
        check("t2_bounce_moves", 8'(bad), 8'd0);
        check("t2_pos", 8'(dino_pos), 8'd0);

        // Second press mid-ascent is ignored
        land_cnt = 0;
        launch("t3");
        run_ticks(5);
        check("t3_pos6", 8'(dino_pos), 8'd6);
        press_left = 20;
        fly_rest("t3", 5);
        repeat (40) step();
        check("t3_no_queue", 8'(dino_state), 8'd0);

        // Death mid-descent freezes position until game_run drops
        launch("t4");
        run_ticks(20);
        check("t4_pos7", 8'(dino_pos), 8'd7);
        check("t4_desc", 8'(dino_state), 8'd3);
        is_alive = 1'b0;
        step();
        check("t4_dead_state", 8'(dino_state), 8'd4);
        check("t4_dead_pos", 8'(dino_pos), 8'd7);
        check("t4_dead_air", 8'(airborne), 8'd0);
        is_alive = 1'b1;
        run_ticks(50);
        check("t4_still_dead", 8'(dino_state), 8'd4);
        check("t4_still_pos", 8'(dino_pos), 8'd7);
        game_run = 1'b0;
        step();
        check("t4_stop_state", 8'(dino_state), 8'd0);
        check("t4_stop_pos", 8'(dino_pos), 8'd0);
        game_run = 1'b1;
        repeat (10) step();

        // Death on the landing tick wins over land
        land_cnt = 0;
        launch("t5");
        run_ticks(26);
        check("t5_pos1", 8'(dino_pos), 8'd1);
        align(0);
        is_alive = 1'b0;
        step();
        check("t5_dead_state", 8'(dino_state), 8'd4);
        check("t5_dead_pos", 8'(dino_pos), 8'd1);
        check("t5_no_land", 8'(land_cnt), 8'd0);
        game_run = 1'b0;
        is_alive = 1'b1;
        step();
        game_run = 1'b1;
        repeat (10) step();

        // Asynchronous reset mid-flight
        launch("t6");
        run_ticks(9);
        check("t6_pos10", 8'(dino_pos), 8'd10);
        #2;
        clr = 1'b0;
        #1;
        check("t6_rst_pos", 8'(dino_pos), 8'd0);
        check("t6_rst_state", 8'(dino_state), 8'd0);
        check("t6_rst_air", 8'(airborne), 8'd0);
        land_cnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        repeat (40) step();
        check("t6_no_land", 8'(land_cnt), 8'd0);
        check("t6_ground", 8'(dino_state), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/dino_jump_ctrl.md
DINO_JUMP_CTRL -- requirements
Module: dino_jump_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive clk cycles the synchronized jump level must hold before it is accepted.
REQ-002 Parameter MAX_H, default 12: apex height in position units; legal range 1..15.
REQ-003 Parameter HANG_TICKS, default 4: frame ticks spent at apex; legal range 1..15.
REQ-004 clk  in  1  master clock; all state updates on the rising edge.
REQ-005 clr  in  1  reset; asynchronous, active-low.
REQ-006 tick  in  1  one-clk-wide frame strobe; all motion advances only on cycles where tick=1.
REQ-007 jump  in  1  raw, asynchronous, bouncing jump button; 1 = pressed.
REQ-008 game_run  in  1  1 = game in running state.
REQ-009 is_alive  in  1  1 = dino alive; 0 = collision detected.
REQ-010 dino_pos  out  4  dino height above ground; 0 = ground.
REQ-011 dino_state  out  3  0 GROUND, 1 ASCEND, 2 HANG, 3 DESCEND, 4 DEAD; codes 5-7 are never driven.
REQ-012 airborne  out  1  1 while dino_state is 1, 2 or 3.
REQ-013 land  out  1  one-clk pulse on landing.

Function
REQ-014 jump SHALL pass through a 2-flop synchronizer before any other use.
- jump_db updates to the synchronized level only after that level has differed from jump_db for DEB_CYCLES consecutive clk cycles.
- Any reversal in between restarts the count.
REQ-015 A 0->1 transition of jump_db SHALL set a pending flag.
- Only while the state is GROUND and game_run=1 and is_alive=1.
- Transitions in any other condition are discarded; there is no double jump and no queued jump.
REQ-016 The pending flag SHALL be cleared when the jump launches, and whenever the state is not GROUND.
REQ-017 GROUND, pending=1, tick=1: next state ASCEND and dino_pos=1 in the same update.
REQ-018 ASCEND, tick=1: dino_pos increments by 1. When the incremented value equals MAX_H, the state becomes HANG in the same update and the hang counter loads 0.
REQ-019 MAX_H=1 boundary: the launch tick of REQ-017 goes directly to HANG.
REQ-020 HANG, tick=1: the hang counter increments. When the counter reaches HANG_TICKS, the state becomes DESCEND; dino_pos is unchanged.
REQ-021 DESCEND, tick=1: dino_pos decrements by 1. When the result is 0, the state becomes GROUND and land=1 for exactly that clk cycle.
REQ-022 dino_pos arithmetic SHALL be 4-bit unsigned.
- It never exceeds MAX_H.
- It never wraps below 0 or above 15.
REQ-023 Priority, evaluated every clk cycle regardless of tick:
- (a) game_run=0: state GROUND, dino_pos=0, pending=0, hang counter=0, debounce state retained.
- (b) else is_alive=0: state DEAD, dino_pos frozen at its current value, pending cleared.
- (c) else the normal transitions of REQ-017 to REQ-021.
REQ-024 DEAD SHALL be left only through (a) of REQ-023; is_alive returning to 1 alone does not exit DEAD.
REQ-025 Simultaneous landing and is_alive=0 on the same cycle: DEAD wins, dino_pos holds its pre-update value, and land is not asserted.
REQ-026 With tick=0 the outputs SHALL hold, except for the DEAD/GROUND forcing of REQ-023.
REQ-027 Outputs SHALL be registered.
- airborne decodes the registered state.
- land is a registered pulse.
- No combinational path exists from any input to any output.

Reset
REQ-028 clr=0 SHALL asynchronously force:
- dino_pos=0, dino_state=0, airborne=0, land=0
- pending=0, hang counter=0, debounce counter=0
- synchronizer flops=0, jump_db=0
REQ-029 Release of clr SHALL take effect on the first clk edge after deassertion.
REQ-030 Reset asserted mid-jump SHALL return to GROUND with no land pulse.

Verification
REQ-031 Press jump clean for 20 clks, game_run=1, is_alive=1, tick every 4 clks:
- Launches at the first tick after debounce plus 2-cycle sync latency: dino_pos=1, state=1.
- Reaches 12 and state=2 after 11 further ticks.
- Holds 4 ticks, then descends 12 ticks to 0.
- land pulses once; state=0.
REQ-032 Bounce jump 0/1 every 5 clks for 100 clks (never stable for 16): no launch, dino_pos stays 0.
REQ-033 Second press while dino_pos=6 ascending: ignored; total airtime is identical to REQ-031; a single land pulse.
REQ-034 is_alive=0 at dino_pos=7 descending:
- state=4, dino_pos=7 frozen for 50 ticks, even with is_alive back at 1.
- game_run=0: state=0, dino_pos=0 next clk.
REQ-035 is_alive=0 on the same cycle as the DESCEND step 1->0: state=4, dino_pos=1, land=0.
REQ-036 clr=0 asynchronously at dino_pos=10 with no clk edge: outputs read 0 immediately; no land pulse after release.
